// File: rtl/audio_psg_pkg.sv
// -----------------------------------------------------------------------------
// audio_psg_pkg
//   Shared definitions for the PSG voice sequencer: waveform codes, attribute
//   word field positions, default sizing, sequencer states and the noise LFSR.
//   No ports (package).
// -----------------------------------------------------------------------------
package audio_psg_pkg;

    localparam int unsigned NUM_VOICES_DEF = 16;
    localparam int unsigned PHASE_W_DEF    = 17;

    typedef enum logic [1:0] {
        WAVE_PULSE = 2'd0,
        WAVE_SAW   = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    // Attribute word layout
    localparam int unsigned FREQ_LSB = 0;
    localparam int unsigned FREQ_MSB = 15;
    localparam int unsigned VOL_LSB  = 16;
    localparam int unsigned VOL_MSB  = 21;
    localparam int unsigned LEN_BIT  = 22;
    localparam int unsigned REN_BIT  = 23;
    localparam int unsigned PW_LSB   = 24;
    localparam int unsigned PW_MSB   = 29;
    localparam int unsigned WAVE_LSB = 30;
    localparam int unsigned WAVE_MSB = 31;

    // x^16 + x^15 + x^13 + x^4 + 1, Fibonacci form: taps on bits 15,14,12,3
    localparam logic [15:0] LFSR_SEED = 16'h0001;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/audio_psg_wavegen.sv
// -----------------------------------------------------------------------------
// audio_psg_wavegen
//   Combinational waveform generator and volume scaler for one voice.
//   Ports:
//     phase_top  in  7   phase[PHASE_W-1 -: 7] (only the top bits shape the wave)
//     wave       in  2   waveform select (wave_e)
//     pw         in  6   pulse width threshold
//     noise      in  6   voice noise latch
//     vol        in  6   linear volume 0..63
//     contrib    out 12  signed contribution s*vol
// -----------------------------------------------------------------------------
module audio_psg_wavegen
    import audio_psg_pkg::*;
(
    input  logic [6:0]         phase_top,
    input  logic [1:0]         wave,
    input  logic [5:0]         pw,
    input  logic [5:0]         noise,
    input  logic [5:0]         vol,
    output logic signed [11:0] contrib
);

    logic [5:0]         u;
    logic [5:0]         s;
    logic signed [11:0] s_ext;
    logic signed [11:0] vol_ext;

    always_comb begin
        u = '0;
        case (wave_e'(wave))
            WAVE_PULSE: u = (phase_top[6:1] < pw) ? 6'd63 : 6'd0;
            WAVE_SAW:   u = phase_top[6:1];
            WAVE_TRI:   u = phase_top[6] ? ~phase_top[5:0] : phase_top[5:0];
            default:    u = noise;
        endcase
        // Offset-binary to two's complement: u - 32
        s       = {~u[5], u[4:0]};
        s_ext   = {{6{s[5]}}, s};
        vol_ext = {6'd0, vol};
        // |s*vol| <= 2016, so the 12-bit product never wraps
        contrib = s_ext * vol_ext;
    end

endmodule

// File: rtl/audio_psg_voice_seq.sv
// -----------------------------------------------------------------------------
// audio_psg_voice_seq
//   Per-sample sweep over all voices of the attribute RAM: reads one word per
//   voice, advances its phase, generates and scales its waveform and sums the
//   result into left/right mixes.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     sample_tick_i    one-cycle strobe starting a sweep
//     attr_rd_en_o     attribute RAM read enable
//     attr_rd_addr_o   voice index being read
//     attr_rd_data_i   attribute word, valid the cycle after the address
//     left_o, right_o  signed mixes, updated with valid_o
//     valid_o          one-cycle pulse when the mixes update
//     busy_o           sweep in progress
//     overrun_o        sticky: tick seen while a sweep was running
// -----------------------------------------------------------------------------
module audio_psg_voice_seq
    import audio_psg_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned PHASE_W    = PHASE_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick_i,
    output logic                          attr_rd_en_o,
    output logic [$clog2(NUM_VOICES)-1:0] attr_rd_addr_o,
    input  logic [31:0]                   attr_rd_data_i,
    output logic signed [15:0]            left_o,
    output logic signed [15:0]            right_o,
    output logic                          valid_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int unsigned AW = $clog2(NUM_VOICES);

    seq_state_e         state;
    logic [PHASE_W-1:0] phase       [NUM_VOICES];
    logic [5:0]         noise_latch [NUM_VOICES];
    logic [15:0]        lfsr;
    logic               data_vld;
    logic [AW-1:0]      proc_idx;
    logic signed [15:0] acc_l;
    logic signed [15:0] acc_r;

    logic [15:0]        freq;
    logic [5:0]         vol;
    logic [5:0]         pw;
    logic [1:0]         wave;
    logic               en_l;
    logic               en_r;
    logic [PHASE_W-1:0] p_cur;
    logic [PHASE_W-1:0] p_new;
    logic signed [11:0] contrib;
    logic signed [15:0] contrib_ext;
    logic signed [15:0] acc_l_nxt;
    logic signed [15:0] acc_r_nxt;
    logic               last_voice;
    logic               noise_load;

    always_comb begin
        freq        = attr_rd_data_i[FREQ_MSB:FREQ_LSB];
        vol         = attr_rd_data_i[VOL_MSB:VOL_LSB];
        pw          = attr_rd_data_i[PW_MSB:PW_LSB];
        wave        = attr_rd_data_i[WAVE_MSB:WAVE_LSB];
        en_l        = attr_rd_data_i[LEN_BIT];
        en_r        = attr_rd_data_i[REN_BIT];
        p_cur       = phase[proc_idx];
        p_new       = p_cur + PHASE_W'(freq);
        contrib_ext = {{4{contrib[11]}}, contrib};
        acc_l_nxt   = acc_l + (en_l ? contrib_ext : 16'sd0);
        acc_r_nxt   = acc_r + (en_r ? contrib_ext : 16'sd0);
        last_voice  = (proc_idx == AW'(NUM_VOICES - 1));
        // Noise resamples whenever phase bit PHASE_W-7 toggles
        noise_load  = (p_new[PHASE_W-7] != p_cur[PHASE_W-7]);
    end

    audio_psg_wavegen u_wavegen (
        .phase_top (p_cur[PHASE_W-1 -: 7]),
        .wave      (wave),
        .pw        (pw),
        .noise     (noise_latch[proc_idx]),
        .vol       (vol),
        .contrib   (contrib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            attr_rd_en_o   <= 1'b0;
            attr_rd_addr_o <= '0;
            left_o         <= '0;
            right_o        <= '0;
            valid_o        <= 1'b0;
            busy_o         <= 1'b0;
            overrun_o      <= 1'b0;
            lfsr           <= LFSR_SEED;
            data_vld       <= 1'b0;
            proc_idx       <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase[i]       <= '0;
                noise_latch[i] <= '0;
            end
        end else begin
            valid_o  <= 1'b0;
            // One-cycle pipeline matching the RAM read latency
            data_vld <= attr_rd_en_o;
            proc_idx <= attr_rd_addr_o;

            if (data_vld) begin
                phase[proc_idx] <= p_new;
                if (noise_load) begin
                    noise_latch[proc_idx] <= lfsr[5:0];
                end
                lfsr  <= lfsr_step(lfsr);
                acc_l <= acc_l_nxt;
                acc_r <= acc_r_nxt;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a tick so sweeps can run back to back
                    if (sample_tick_i) begin
                        state          <= ST_RUN;
                        busy_o         <= 1'b1;
                        attr_rd_en_o   <= 1'b1;
                        attr_rd_addr_o <= '0;
                        acc_l          <= '0;
                        acc_r          <= '0;
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (sample_tick_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (attr_rd_en_o) begin
                        if (attr_rd_addr_o == AW'(NUM_VOICES - 1)) begin
                            attr_rd_en_o   <= 1'b0;
                            attr_rd_addr_o <= '0;
                        end else begin
                            attr_rd_addr_o <= attr_rd_addr_o + AW'(1);
                        end
                    end
                    if (data_vld && last_voice) begin
                        state   <= ST_DONE;
                        left_o  <= acc_l_nxt;
                        right_o <= acc_r_nxt;
                        valid_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_psg_voice_seq.sv
// -----------------------------------------------------------------------------
// tb_audio_psg_voice_seq
//   Self-checking bench for audio_psg_voice_seq with a registered RAM model and
//   an arithmetic reference of the voice mixing rules.
// -----------------------------------------------------------------------------
module tb_audio_psg_voice_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic               rd_en;
    logic [3:0]         addr;
    logic [31:0]        rd_data;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               valid;
    logic               busy;
    logic               ovr;

    always #5 clk = ~clk;

    audio_psg_voice_seq #(.NUM_VOICES(16), .PHASE_W(17)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_tick_i  (tick),
        .attr_rd_en_o   (rd_en),
        .attr_rd_addr_o (addr),
        .attr_rd_data_i (rd_data),
        .left_o         (left),
        .right_o        (right),
        .valid_o        (valid),
        .busy_o         (busy),
        .overrun_o      (ovr)
    );

    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[addr];
    end

    int tests = 0;
    int fails = 0;

    int mphase [16];
    int mnoise [16];
    int mlfsr;
    bit movr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] word(input int freq, input int vol, input int l,
                                         input int r, input int pw, input int wave);
        int w;
        w = (wave << 30) | (pw << 24) | (r << 23) | (l << 22) | (vol << 16) | freq;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mphase[i] = 0;
            mnoise[i] = 0;
        end
        mlfsr = 1;
        movr  = 0;
    endtask

    task automatic model_sweep(output int el, output int er);
        int al, ar, p, pn, u, c, fb;
        int freq, vol, le, re, pw, wave;
        logic [31:0] w;
        al = 0;
        ar = 0;
        for (int v = 0; v < 16; v++) begin
            w    = ram[v];
            freq = int'(w & 32'hFFFF);
            vol  = int'((w >> 16) & 32'h3F);
            le   = int'((w >> 22) & 32'h1);
            re   = int'((w >> 23) & 32'h1);
            pw   = int'((w >> 24) & 32'h3F);
            wave = int'((w >> 30) & 32'h3);
            p    = mphase[v];
            case (wave)
                0:       u = (p / 2048 < pw) ? 63 : 0;
                1:       u = p / 2048;
                2:       u = (p >= 65536) ? 63 - ((p / 1024) % 64) : (p / 1024) % 64;
                default: u = mnoise[v];
            endcase
            c = (u - 32) * vol;
            if (le == 1) al += c;
            if (re == 1) ar += c;
            pn = (p + freq) % 131072;
            if (((pn / 1024) % 2) != ((p / 1024) % 2)) mnoise[v] = mlfsr % 64;
            mphase[v] = pn;
            fb    = ((mlfsr >> 15) ^ (mlfsr >> 14) ^ (mlfsr >> 12) ^ (mlfsr >> 3)) & 1;
            mlfsr = ((mlfsr << 1) | fb) & 65535;
        end
        el = al;
        er = ar;
    endtask

    // Starts a sweep from a cycle just after an edge and ends in cycle T+18.
    task automatic sweep(input string tag, input bit tcheck, input int extra_k);
        int el, er, early;
        early = 0;
        model_sweep(el, er);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (tcheck && k <= 16) begin
                check({tag, "_addr"}, 32'(addr), 32'(k - 1));
                check({tag, "_rden"}, 32'(rd_en), 32'd1);
            end
            if (tcheck && k == 17) check({tag, "_rden_off"}, 32'(rd_en), 32'd0);
            if (tcheck) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (k < 18 && valid) early++;
            if (k == extra_k && k < 18) begin
                tick = 1'b1;
                movr = 1;
            end else begin
                tick = 1'b0;
            end
            if (k < 18) begin
                @(posedge clk); #1;
            end
        end
        tick = 1'b0;
        check({tag, "_early_valid"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd1);
        check({tag, "_left"}, sx(left), el);
        check({tag, "_right"}, sx(right), er);
        check({tag, "_ovr"}, 32'(ovr), 32'(movr));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic ram_fill(input logic [31:0] w0, input logic [31:0] rest);
        ram[0] = w0;
        for (int i = 1; i < 16; i++) ram[i] = rest;
    endtask

    initial begin
        int cnt;
        rst  = 1'b1;
        tick = 1'b0;
        ram_fill('0, '0);
        model_reset();

        // Reset state
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_left", sx(left), 32'd0);
        check("rst_right", sx(right), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_rden", 32'(rd_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero RAM sweep with full timing checks
        sweep("s1", 1'b1, 0);
        @(posedge clk); #1;
        check("s1_idle_busy", 32'(busy), 32'd0);
        check("s1_idle_valid", 32'(valid), 32'd0);

        // Saw on voice 0, left only
        ram_fill(word(16'h0800, 63, 1, 0, 0, 1), '0);
        for (int t = 1; t <= 65; t++) begin
            sweep("s2", 1'b0, 0);
            if (t == 1)  check("s2_t1", sx(left), -2016);
            if (t == 2)  check("s2_t2", sx(left), -1953);
            if (t == 64) check("s2_t64", sx(left), 1953);
            if (t == 65) check("s2_t65_wrap", sx(left), -2016);
        end

        // Pulse pw=32, vol=1, both channels
        do_reset();
        ram_fill(word(16'h0800, 1, 1, 1, 32, 0), '0);
        for (int t = 1; t <= 64; t++) begin
            sweep("s3", 1'b0, 0);
            if (t == 1)  check("s3_t1", sx(right), 31);
            if (t == 32) check("s3_t32", sx(left), 31);
            if (t == 33) check("s3_t33", sx(left), -32);
            if (t == 64) check("s3_t64", sx(right), -32);
        end

        // Accumulator extremes
        do_reset();
        ram_fill(word(0, 63, 1, 1, 63, 0), word(0, 63, 1, 1, 63, 0));
        sweep("s4p", 1'b0, 0);
        check("s4_pulse_max", sx(left), 31248);
        do_reset();
        ram_fill(word(0, 63, 1, 1, 0, 1), word(0, 63, 1, 1, 0, 1));
        sweep("s4s", 1'b0, 0);
        check("s4_saw_min", sx(right), -32256);

        // Overrun, then a back-to-back tick at T+18
        do_reset();
        ram_fill(word(16'h0800, 63, 1, 0, 0, 1), '0);
        sweep("s5a", 1'b1, 5);
        sweep("s5b", 1'b1, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("s5_ovr_sticky", 32'(ovr), 32'd1);
        do_reset();
        check("s5_ovr_cleared", 32'(ovr), 32'd0);

        // Randomized voices, all waveforms including noise
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] = word(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 63)),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
            end
            sweep("rnd", (t < 2), 0);
        end

        // Reset mid-sweep
        ram_fill(word(16'h0800, 63, 1, 0, 0, 1), '0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cnt = 0;
        repeat (20) begin
            if (valid) cnt++;
            @(posedge clk); #1;
        end
        check("s6_no_valid", 32'(cnt), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_rden", 32'(rd_en), 32'd0);
        check("s6_left", sx(left), 32'd0);
        sweep("s6", 1'b1, 0);
        check("s6_t1", sx(left), -2016);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
